// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage controller: FSM encoding, control-word bit
// positions and the load-data extension helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BASE_WB  = 2'd2
    } state_t;

    localparam int MC_RD      = 0;
    localparam int MC_WR      = 1;
    localparam int MC_BASE_WB = 2;
    localparam int MC_BYTE    = 3;

    localparam int WB_REG_WRITE  = 0;
    localparam int WB_MEM_TO_REG = 1;

    // Byte loads return the low byte zero-extended; word loads pass through.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic is_byte);
        return is_byte ? {24'd0, rdata[7:0]} : rdata;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM-stage controller (master)
// and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_byte;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_controller.sv
// MEM-stage sequencer: one data access per load/store, then load-data and optional
// post-index base writeback share the single register-file write port.
module mem_stage_controller
    import mem_stage_pkg::*;
#(
    parameter int MEM_CTRL_W = 7,
    parameter int WB_CTRL_W  = 2,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           mem_data_write,
    input  logic [31:0]           base_reg_content,
    input  logic [3:0]            wb_address,
    input  logic [3:0]            base_register_address,
    input  logic [MEM_CTRL_W-1:0] mem_control,
    input  logic [WB_CTRL_W-1:0]  wb_control,
    mem_stage_if.master           dmem,
    output logic                  stall,
    output logic                  rf_we,
    output logic [3:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  mem_error
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               req_reg, req_next;
    logic               we_reg, we_next;
    logic               byte_reg, byte_next;
    logic [31:0]        addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic               rf_we_reg, rf_we_next;
    logic [3:0]         rf_waddr_reg, rf_waddr_next;
    logic [31:0]        rf_wdata_reg, rf_wdata_next;
    logic               err_reg, err_next;
    logic               load_wr_reg, load_wr_next;
    logic               base_pend_reg, base_pend_next;
    logic [3:0]         wb_addr_reg, wb_addr_next;
    logic [3:0]         base_addr_reg, base_addr_next;
    logic [31:0]        base_data_reg, base_data_next;

    logic in_rd, in_wr, in_load;
    logic unused_reserved_bits;

    assign in_rd   = mem_control[MC_RD];
    assign in_wr   = mem_control[MC_WR];
    // A request with both rd and wr set is performed as a store.
    assign in_load = in_rd & ~in_wr;
    assign unused_reserved_bits = ^mem_control[MEM_CTRL_W-1:MC_BYTE+1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            byte_reg      <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rf_we_reg     <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            err_reg       <= 1'b0;
            load_wr_reg   <= 1'b0;
            base_pend_reg <= 1'b0;
            wb_addr_reg   <= '0;
            base_addr_reg <= '0;
            base_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            byte_reg      <= byte_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rf_we_reg     <= rf_we_next;
            rf_waddr_reg  <= rf_waddr_next;
            rf_wdata_reg  <= rf_wdata_next;
            err_reg       <= err_next;
            load_wr_reg   <= load_wr_next;
            base_pend_reg <= base_pend_next;
            wb_addr_reg   <= wb_addr_next;
            base_addr_reg <= base_addr_next;
            base_data_reg <= base_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        req_next       = req_reg;
        we_next        = we_reg;
        byte_next      = byte_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rf_we_next     = 1'b0;
        rf_waddr_next  = rf_waddr_reg;
        rf_wdata_next  = rf_wdata_reg;
        err_next       = err_reg;
        load_wr_next   = load_wr_reg;
        base_pend_next = base_pend_reg;
        wb_addr_next   = wb_addr_reg;
        base_addr_next = base_addr_reg;
        base_data_next = base_data_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (valid_in) begin
                    if (in_rd | in_wr) begin
                        load_wr_next   = in_load & wb_control[WB_REG_WRITE]
                                         & wb_control[WB_MEM_TO_REG];
                        base_pend_next = mem_control[MC_BASE_WB] & wb_control[WB_REG_WRITE];
                        wb_addr_next   = wb_address;
                        base_addr_next = base_register_address;
                        base_data_next = base_reg_content;
                        req_next       = 1'b1;
                        we_next        = in_wr;
                        byte_next      = mem_control[MC_BYTE];
                        addr_next      = alu_result;
                        wdata_next     = mem_data_write;
                        cnt_next       = '0;
                        state_next     = ST_MEM_WAIT;
                    end else begin
                        rf_we_next    = wb_control[WB_REG_WRITE];
                        rf_waddr_next = wb_address;
                        rf_wdata_next = alu_result;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (dmem.dmem_ready) begin
                    req_next  = 1'b0;
                    we_next   = 1'b0;
                    byte_next = 1'b0;
                    if (load_wr_reg) begin
                        rf_we_next    = 1'b1;
                        rf_waddr_next = wb_addr_reg;
                        rf_wdata_next = load_extend(dmem.dmem_rdata, byte_reg);
                    end
                    // Base register equal to the load destination: loaded data wins.
                    if (base_pend_reg && !(load_wr_reg && base_addr_reg == wb_addr_reg))
                        state_next = ST_BASE_WB;
                    else
                        state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    byte_next  = 1'b0;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_BASE_WB: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = base_addr_reg;
                rf_wdata_next = base_data_reg;
                state_next    = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign stall           = (state_reg != ST_IDLE);
    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_byte  = byte_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_wdata = wdata_reg;
    assign rf_we           = rf_we_reg;
    assign rf_waddr        = rf_waddr_reg;
    assign rf_wdata        = rf_wdata_reg;
    assign mem_error       = err_reg;

endmodule
